pipe_mux_n: RTL and testbench
=============================

Name: pipe_mux_n

Overview:
- Parametrised successor to the 2:1 32-bit datapath mux: NUM_IN-way, WIDTH-bit selector with a registered output stage and valid/ready handshake.
- Sits between multicycle-CPU datapath sources (PC, register file, immediates, ALUOut) and consumers whose acceptance may stall.
- A 2-entry skid buffer gives full throughput while InReady stays a function of register state only.
- Out-of-range selects are trapped and flagged instead of producing undefined data.

Parameters:
- WIDTH, 32, data width per input and output.
- NUM_IN, 4, number of mux inputs; legal range 2..16.
- SEL_W, 2, select width; must satisfy 2^SEL_W >= NUM_IN (instance-time check, elaboration error if violated).

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- In  input  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
- Sel  input  SEL_W  input select, sampled with InValid.
- InValid  input  1  producer offers In/Sel this cycle.
- InReady  output  1  block accepts this cycle; high when the skid entry is empty.
- Out  output  WIDTH  selected data, registered.
- OutValid  output  1  Out holds a valid word.
- OutReady  input  1  consumer accepts Out this cycle.
- SelErr  output  1  sticky flag: an out-of-range Sel (>= NUM_IN) was accepted.
- ErrClr  input  1  synchronous clear of SelErr.

Behaviour:
- Handshakes:
  - Accept = InValid & InReady.
  - Output transfer = OutValid & OutReady.
  - Both are evaluated on the same rising edge.
- Storage: main register (drives Out/OutValid) and one skid register (SkidData, SkidValid).
- InReady = ~SkidValid, a combinational function of state only, with no path from InValid or OutReady. InReady is 1 while in reset.
- Captured word: In[Sel] when Sel < NUM_IN; all-zero when Sel >= NUM_IN.
- Latency: 1 cycle. A word accepted at edge n is on Out after edge n with OutValid=1.
- Next-state rules, applied per edge in priority order:
  1. Main empty or transferring, skid full: skid word moves to main; skid is cleared; a new accept is impossible because InReady=0.
  2. Main empty or transferring, skid empty, accept: new word goes into main.
  3. Main empty or transferring, skid empty, no accept: OutValid goes to 0. Out holds its last value; it is don't-care but must not change.
  4. Main full and not transferring, accept: new word goes into skid; SkidValid=1.
  5. Main full and not transferring, no accept: hold.
- Stall rules:
  - Out and OutValid must not change while OutValid=1 and OutReady=0.
  - Data order is strictly FIFO across main and skid.
- Throughput: with OutReady held at 1, one word per cycle, indefinitely.
- SelErr:
  - Set on the edge that accepts a word with Sel >= NUM_IN.
  - ErrClr clears it.
  - If set and clear occur on the same edge, set wins.
  - The erroneous word is still delivered (as zero); no data is dropped.
  - A Sel value presented without an accept has no effect.
- Reset, at any time including mid-transfer, forces immediately:
  - OutValid=0, Out=0, SkidValid=0, SkidData=0, SelErr=0.
  - All in-flight words are discarded.
  - The first edge after Rst_n rises may accept.
- X-safety: while OutValid=0, Out must never carry X after the first reset.

Test Plan:
- Basic select (WIDTH=32, NUM_IN=4): In0=FFFFFFFF, In1=AAAAAAAA, In2=12345678, In3=00000000. OutReady=1; issue Sel=1,0,2,3 on consecutive cycles with InValid=1 -> Out = AAAAAAAA, FFFFFFFF, 12345678, 00000000 on cycles 1..4; OutValid continuous; InReady stays 1.
- Backpressure/skid: OutReady=0, send Sel=0 then Sel=1 -> after edge 2, Out=FFFFFFFF held and InReady=0. Raise OutReady -> next edge Out=AAAAAAAA, InReady=1; nothing lost or duplicated.
- Out-of-range: NUM_IN=3, SEL_W=2, Sel=3 accepted -> Out=00000000 with OutValid=1 and SelErr=1. ErrClr pulse -> SelErr=0. ErrClr together with a second Sel=3 accept -> SelErr stays 1.
- Reset mid-operation: main and skid full, OutReady=0; assert Rst_n=0 between edges -> OutValid=0, Out=0, InReady=1, SelErr=0 without waiting for a clock edge. Release -> first accept appears after 1 cycle.
- Random stress: 1000 cycles of random InValid/OutReady/Sel against a scoreboard model -> zero mismatches; output order equals accept order; Out stable whenever OutValid=1 and OutReady=0.

Source files
------------

// File: rtl/pipe_mux_n.sv
// NUM_IN-way, WIDTH-bit selector with a registered output and a 2-entry skid buffer.
// InReady depends only on register state; out-of-range selects deliver zero and raise a sticky flag.
module pipe_mux_n #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [NUM_IN*WIDTH-1:0] In,
    input  logic [SEL_W-1:0]        Sel,
    input  logic                    InValid,
    output logic                    InReady,
    output logic [WIDTH-1:0]        Out,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic                    SelErr,
    input  logic                    ErrClr
);

    generate
        if (NUM_IN < 2 || NUM_IN > 16 || (1 << SEL_W) < NUM_IN) begin : g_bad_params
            $error("pipe_mux_n: NUM_IN must be 2..16 and 2**SEL_W >= NUM_IN");
        end
    endgenerate

    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             sel_err_q, sel_err_d;

    logic [WIDTH-1:0] sel_word;
    logic             sel_oob;
    logic             accept;

    // Unmatched (out-of-range) selects fall through to the all-zero default.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (Sel == SEL_W'(k)) begin
                sel_word = In[k*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_oob = (32'(Sel) >= 32'(NUM_IN));
    assign accept  = InValid & ~skid_valid_q;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        sel_err_d    = (accept & sel_oob) | (sel_err_q & ~ErrClr);

        // Main register is free this edge: refill from skid first to keep FIFO order.
        if (!out_valid_q || OutReady) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = sel_word;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = sel_word;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            sel_err_q    <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            sel_err_q    <= sel_err_d;
        end
    end

    assign InReady  = ~skid_valid_q;
    assign Out      = out_q;
    assign OutValid = out_valid_q;
    assign SelErr   = sel_err_q;

endmodule

// File: tb/tb_pipe_mux_n.sv
// Bench for pipe_mux_n: a 4-input and a 3-input instance share one stimulus stream;
// an occupancy/queue model predicts handshakes, data order and the sticky select error.
module tb_pipe_mux_n;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] in_vec;
    logic [1:0]   sel;
    logic         in_valid;
    logic         out_ready;
    logic         err_clr;

    logic        in_ready4, out_valid4, sel_err4;
    logic [31:0] out4;
    logic        in_ready3, out_valid3, sel_err3;
    logic [31:0] out3;

    int checks = 0;
    int errors = 0;

    // Reference model state: words in flight, expected words in order, sticky flag.
    int          occ = 0;
    logic        err3_m = 1'b0;
    logic [31:0] exp_q4[$];
    logic [31:0] exp_q3[$];
    logic [31:0] last4 = '0;
    logic [31:0] last3 = '0;

    pipe_mux_n #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) u_dut4 (
        .Clk(clk), .Rst_n(rst_n), .In(in_vec), .Sel(sel), .InValid(in_valid),
        .InReady(in_ready4), .Out(out4), .OutValid(out_valid4), .OutReady(out_ready),
        .SelErr(sel_err4), .ErrClr(err_clr)
    );

    pipe_mux_n #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) u_dut3 (
        .Clk(clk), .Rst_n(rst_n), .In(in_vec[95:0]), .Sel(sel), .InValid(in_valid),
        .InReady(in_ready3), .Out(out3), .OutValid(out_valid3), .OutReady(out_ready),
        .SelErr(sel_err3), .ErrClr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a word is accepted while fewer than two are held; one leaves per ready cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ    = 0;
            err3_m = 1'b0;
            exp_q4.delete();
            exp_q3.delete();
            last4  = '0;
            last3  = '0;
        end else begin
            logic acc, xf;
            logic [31:0] w;
            acc = in_valid && (occ < 2);
            xf  = (occ > 0) && out_ready;
            if (acc) begin
                w = in_vec[32*int'(sel) +: 32];
                exp_q4.push_back(w);
                exp_q3.push_back((sel < 2'd3) ? w : 32'h0);
            end
            err3_m = (acc && sel == 2'd3) || (err3_m && !err_clr);
            occ    = occ + int'(acc) - int'(xf);
        end
    end

    task automatic mon_one(input int d, input logic [31:0] o, input logic ov,
                           input logic ir, input logic se);
        int sz;
        logic [31:0] e;
        check(d ? "ready3" : "ready4", 32'(ir), 32'(occ < 2));
        check(d ? "valid3" : "valid4", 32'(ov), 32'(occ > 0));
        check(d ? "selerr3" : "selerr4", 32'(se), d ? 32'(err3_m) : 32'h0);
        if (ov) begin
            sz = d ? exp_q3.size() : exp_q4.size();
            if (sz == 0) begin
                check(d ? "unexpected_word3" : "unexpected_word4", o, 32'hDEADBEEF ^ o);
            end else begin
                e = d ? exp_q3[0] : exp_q4[0];
                check(d ? "data3" : "data4", o, e);
                if (out_ready) begin
                    if (d) begin void'(exp_q3.pop_front()); last3 = e; end
                    else   begin void'(exp_q4.pop_front()); last4 = e; end
                end
            end
        end else begin
            check(d ? "idle_hold3" : "idle_hold4", o, d ? last3 : last4);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon_one(0, out4, out_valid4, in_ready4, sel_err4);
            mon_one(1, out3, out_valid3, in_ready3, sel_err3);
        end
    end

    task automatic cycle(input logic v, input logic [1:0] s, input logic rdy, input logic clr);
        in_valid  = v;
        sel       = s;
        out_ready = rdy;
        err_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        check("rst_valid4", 32'(out_valid4), 32'h0);
        check("rst_out4", out4, 32'h0);
        check("rst_ready4", 32'(in_ready4), 32'h1);
        check("rst_valid3", 32'(out_valid3), 32'h0);
        check("rst_out3", out3, 32'h0);
        check("rst_ready3", 32'(in_ready3), 32'h1);
        check("rst_selerr3", 32'(sel_err3), 32'h0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_vec    = {32'h0000_0000, 32'h1234_5678, 32'hAAAA_AAAA, 32'hFFFF_FFFF};
        sel       = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        #1;
        check_reset_state();
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Basic select, full rate.
        cycle(1, 2'd1, 1, 0); check("basic_sel1", out4, 32'hAAAA_AAAA);
        cycle(1, 2'd0, 1, 0); check("basic_sel0", out4, 32'hFFFF_FFFF);
        cycle(1, 2'd2, 1, 0); check("basic_sel2", out4, 32'h1234_5678);
        check("basic_ready", 32'(in_ready4), 32'h1);
        cycle(1, 2'd3, 1, 0); check("basic_sel3", out4, 32'h0);
        check("oob_out3", out3, 32'h0);
        check("oob_valid3", 32'(out_valid3), 32'h1);
        check("oob_err3", 32'(sel_err3), 32'h1);
        cycle(0, 2'd3, 1, 0); check("drain_valid", 32'(out_valid4), 32'h0);
        check("err_sticky", 32'(sel_err3), 32'h1);

        // Sticky error clear, then clear racing a new set.
        cycle(0, 2'd3, 1, 1); check("err_cleared", 32'(sel_err3), 32'h0);
        cycle(1, 2'd3, 1, 1); check("err_set_wins", 32'(sel_err3), 32'h1);
        cycle(0, 2'd0, 1, 1); check("err_cleared2", 32'(sel_err3), 32'h0);

        // Backpressure into the skid entry.
        cycle(1, 2'd0, 0, 0); check("bp_first", out4, 32'hFFFF_FFFF);
        cycle(1, 2'd1, 0, 0); check("bp_hold", out4, 32'hFFFF_FFFF);
        check("bp_ready_low", 32'(in_ready4), 32'h0);
        cycle(1, 2'd2, 1, 0); check("bp_skid_out", out4, 32'hAAAA_AAAA);
        check("bp_ready_high", 32'(in_ready4), 32'h1);
        cycle(0, 2'd0, 1, 0); check("bp_empty", 32'(out_valid4), 32'h0);

        // Asynchronous reset with main and skid full.
        cycle(1, 2'd3, 0, 0);
        cycle(1, 2'd1, 0, 0); check("pre_rst_full", 32'(in_ready4), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1, 2'd2, 1, 0); check("post_rst_data", out4, 32'h1234_5678);
        check("post_rst_valid", 32'(out_valid4), 32'h1);

        // Random stress with phases of heavy and light backpressure.
        for (int i = 0; i < 1000; i++) begin
            in_vec = {$urandom, $urandom, $urandom, $urandom};
            cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  ((i / 100) % 2 == 0) ? 1'($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 15) == 0));
        end

        for (int i = 0; i < 4; i++) cycle(0, 2'd0, 1, 0);
        check("final_q4_empty", 32'(exp_q4.size()), 32'h0);
        check("final_q3_empty", 32'(exp_q3.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
